// File: rtl/reg_dump_serializer_if.sv
// Byte stream from the register dump serializer to a UART-style transmitter.
// Data/valid flow to the transmitter; ready flows back.
interface reg_dump_serializer_if;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;

  modport master (
    output o_tx_data,
    output o_tx_valid,
    input  i_tx_ready
  );

  modport slave (
    input  o_tx_data,
    input  o_tx_valid,
    output i_tx_ready
  );
endinterface

// File: rtl/reg_dump_serializer.sv
// Snapshots a flattened register bank and streams it out MSB-first,
// one byte per valid/ready transfer, with abort and completion pulse.
module reg_dump_serializer #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int BYTES_PER_REG = SIZE / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [SIZE*NUM_REGISTERS-1:0] i_registers_debug,
  reg_dump_serializer_if.master         tx,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int RW = (NUM_REGISTERS > 1) ?
                      $clog2(NUM_REGISTERS) : 1;
  localparam int BW = (BYTES_PER_REG > 1) ?
                      $clog2(BYTES_PER_REG) : 1;
  localparam int IW = SIZE * NUM_REGISTERS;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   snap;
  logic [RW-1:0]   r;
  logic [BW-1:0]   b;

  // Byte 0 of a register is its most significant byte.
  function automatic logic [7:0] byte_of(
    input logic [IW-1:0] img,
    input int            ri,
    input int            bi
  );
    return img[ri*SIZE + SIZE - 8 - 8*bi +: 8];
  endfunction

  wire last_b = (b == BW'(BYTES_PER_REG - 1));
  wire last_r = (r == RW'(NUM_REGISTERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      snap          <= '0;
      r             <= '0;
      b             <= '0;
      tx.o_tx_data  <= '0;
      tx.o_tx_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else if (i_abort) begin
      state         <= IDLE;
      r             <= '0;
      b             <= '0;
      tx.o_tx_data  <= '0;
      tx.o_tx_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            snap          <= i_registers_debug;
            r             <= '0;
            b             <= '0;
            tx.o_tx_data  <= byte_of(i_registers_debug, 0, 0);
            tx.o_tx_valid <= 1'b1;
            o_busy        <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          if (tx.i_tx_ready) begin
            if (!last_b) begin
              b            <= b + 1'b1;
              tx.o_tx_data <= byte_of(snap, int'(r), int'(b) + 1);
            end else if (!last_r) begin
              b            <= '0;
              r            <= r + 1'b1;
              tx.o_tx_data <= byte_of(snap, int'(r) + 1, 0);
            end else begin
              b             <= '0;
              tx.o_tx_data  <= '0;
              tx.o_tx_valid <= 1'b0;
              o_done        <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          r      <= '0;
          state  <= IDLE;
        end
        default: begin
          tx.o_tx_valid <= 1'b0;
          o_busy        <= 1'b0;
          o_done        <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Bench for reg_dump_serializer: directed scenarios with random images
// and random backpressure, checked against a byte-list model.
module tb_reg_dump_serializer;
  localparam int N     = 32;
  localparam int BPR   = 4;
  localparam int TOTAL = N * BPR;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_start;
  logic           i_abort;
  logic           o_busy;
  logic           o_done;
  logic [32*N-1:0] regs_bus;
  logic [31:0]    img [N];
  logic [7:0]     got [$];
  int             n_cmp = 0;
  int             n_fail = 0;

  reg_dump_serializer_if tx ();

  reg_dump_serializer dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .i_registers_debug (regs_bus),
    .tx                (tx),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected byte k of the dump: register k/4, MSB first.
  function automatic logic [7:0] model_byte(input int k);
    int ri = k / BPR;
    int bi = k % BPR;
    return 8'((img[ri] >> (8 * (BPR - 1 - bi))) & 32'hFF);
  endfunction

  task automatic load_bus();
    for (int k = 0; k < N; k++) regs_bus[k*32 +: 32] = img[k];
  endtask

  task automatic run_dump(input int  rdy_mode,
                          input int  start_at,
                          input int  abort_at,
                          input int  rst_at,
                          input bit  freeze);
    int   nb = 0;
    int   nd = 0;
    int   last = -10;
    bit   hold = 1'b0;
    bit   rdy;
    logic [7:0] held = '0;
    got.delete();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (freeze && cyc == 0) regs_bus = '1;
      if (o_done) begin
        nd++;
        check("done_after_last", 64'(cyc), 64'(last + 1));
      end
      if (!o_busy) break;
      if (!o_done) check("valid_in_send", tx.o_tx_valid, 1);
      else         check("valid_in_done", tx.o_tx_valid, 0);
      if (hold) check("held_byte", tx.o_tx_data, held);
      if (nb == abort_at) begin
        i_abort = 1'b1;
        i_start = 1'b1;
        tx.i_tx_ready = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        i_start = 1'b0;
        check("abort_outs", {tx.o_tx_valid, o_busy, o_done}, 0);
        @(posedge clk); #1;
        check("abort_no_done", {tx.o_tx_valid, o_busy, o_done}, 0);
        return;
      end
      if (nb == rst_at) begin
        tx.i_tx_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs",
              {tx.o_tx_data, tx.o_tx_valid, o_busy, o_done}, 0);
        #1 rst = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("post_rst_idle", {tx.o_tx_valid, o_busy, o_done}, 0);
        end
        return;
      end
      i_start = (nb == start_at);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx.i_tx_ready = rdy;
      if (tx.o_tx_valid && rdy) begin
        if (nb < TOTAL) check("byte", tx.o_tx_data, model_byte(nb));
        else            check("extra_byte", 64'(nb), 64'(TOTAL - 1));
        got.push_back(tx.o_tx_data);
        nb++;
        last = cyc;
        hold = 1'b0;
      end else begin
        hold = tx.o_tx_valid;
        held = tx.o_tx_data;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    check("dump_len", 64'(nb), 64'(TOTAL));
    check("done_count", 64'(nd), 64'(1));
    check("idle_after", {o_busy, tx.o_tx_valid}, 0);
  endtask

  task automatic check_basic_bytes(input string tag);
    logic [31:0] w4;
    logic [31:0] wl;
    check({tag, "_size"}, 64'(got.size()), 64'(TOTAL));
    if (got.size() == TOTAL) begin
      w4 = {got[4], got[5], got[6], got[7]};
      wl = {got[124], got[125], got[126], got[127]};
      check({tag, "_bytes4_7"}, w4, 32'h0100_0001);
      check({tag, "_last4"}, wl, 32'h1F00_001F);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    tx.i_tx_ready = 1'b0;
    for (int k = 0; k < N; k++) img[k] = 32'h0100_0000 * k + k;
    load_bus();
    #12;
    check("reset_outs",
          {tx.o_tx_data, tx.o_tx_valid, o_busy, o_done}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    tx.i_tx_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ignores_ready", {tx.o_tx_valid, o_busy, o_done}, 0);
    end

    run_dump(0, -1, -1, -1, 1'b0);
    check_basic_bytes("basic");

    run_dump(1, -1, -1, -1, 1'b0);
    check_basic_bytes("backpressure");

    for (int k = 0; k < N; k++) img[k] = $urandom;
    load_bus();
    run_dump(0, -1, -1, -1, 1'b1);
    load_bus();

    run_dump(0, 10, -1, -1, 1'b0);

    run_dump(0, -1, 50, -1, 1'b0);
    run_dump(2, -1, -1, -1, 1'b0);

    for (int k = 0; k < N; k++) img[k] = $urandom;
    load_bus();
    run_dump(2, 37, -1, -1, 1'b0);

    run_dump(0, -1, -1, 20, 1'b0);
    run_dump(2, -1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
